// File: rtl/red_pitaya_denormalizer_block.sv
// Restores absolute amplitude to a normalized stream: signal * mean|amplitude| / setpoint.
// Define DENORM_ROUND_EN to round half up in the output stage instead of flooring.
module red_pitaya_denormalizer_block #(
    parameter int SIGNALBITS  = 14,
    parameter int SCALEBITS   = 16,
    parameter int FRACBITS    = 12,
    parameter int WINDOW_LOG2 = 10
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         denorm_on,
    input  logic signed [SIGNALBITS-1:0] signal_i,
    input  logic signed [SIGNALBITS-1:0] amplitude_i,
    input  logic        [SIGNALBITS-2:0] setpoint_i,
    output logic signed [SIGNALBITS-1:0] signal_o,
    output logic        [SCALEBITS-1:0]  scale_o,
    output logic                         scale_valid_o,
    output logic                         overrun_o
);

    localparam int MAGBITS  = SIGNALBITS - 1;
    localparam int ACCBITS  = WINDOW_LOG2 + MAGBITS;
    localparam int PRODBITS = SIGNALBITS + SCALEBITS + 1;
    localparam int HEADBITS = SCALEBITS - FRACBITS;
    localparam int BITW     = $clog2(SCALEBITS);

    localparam logic [SCALEBITS-1:0] SCALE_ONE = SCALEBITS'(2 ** FRACBITS);
    localparam logic signed [PRODBITS-1:0] SAT_HI = PRODBITS'(2 ** (SIGNALBITS - 1) - 1);
    localparam logic signed [PRODBITS-1:0] SAT_LO = ~SAT_HI;
`ifdef DENORM_ROUND_EN
    localparam logic signed [PRODBITS-1:0] RND = PRODBITS'(2 ** (FRACBITS - 1));
`else
    localparam logic signed [PRODBITS-1:0] RND = '0;
`endif

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t state_q, state_d;

    logic [MAGBITS-1:0]     mag_q;
    logic [WINDOW_LOG2-1:0] cnt_q;
    logic [ACCBITS-1:0]     acc_q;
    logic [ACCBITS-1:0]     acc_sum;
    logic [MAGBITS-1:0]     mean;
    logic                   wrap;

    logic [MAGBITS-1:0]   sp_q;
    logic [MAGBITS-1:0]   rem_q;
    logic [MAGBITS-1:0]   rem_next;
    logic [SCALEBITS-1:0] low_q;
    logic [SCALEBITS-1:0] quo_q;
    logic                 sat_q;
    logic [BITW-1:0]      bit_q;
    logic                 last_bit;
    logic [MAGBITS:0]     trial;
    logic [MAGBITS:0]     diff;
    logic                 ge;

    logic signed [PRODBITS-1:0]   sig_ext;
    logic signed [PRODBITS-1:0]   scl_ext;
    logic signed [PRODBITS-1:0]   prod_d;
    logic signed [PRODBITS-1:0]   prod_q;
    logic signed [PRODBITS-1:0]   sum_d;
    logic signed [PRODBITS-1:0]   shifted;
    logic signed [SIGNALBITS-1:0] out_d;

    // Ones complement magnitude; the reference is free-running, so no reset.
    always_ff @(posedge clk_i) begin
        if (amplitude_i[SIGNALBITS-1])
            mag_q <= ~amplitude_i[MAGBITS-1:0];
        else
            mag_q <= amplitude_i[MAGBITS-1:0];
    end

    assign acc_sum = acc_q + ACCBITS'(mag_q);
    assign wrap    = &cnt_q;
    assign mean    = acc_sum[ACCBITS-1:WINDOW_LOG2];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_q + WINDOW_LOG2'(1);
            acc_q <= wrap ? '0 : acc_sum;
        end
    end

    assign last_bit = (bit_q == BITW'(SCALEBITS - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (wrap) state_d = DIV;
            DIV:     if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            scale_o       <= SCALE_ONE;
            scale_valid_o <= 1'b0;
            overrun_o     <= 1'b0;
        end else begin
            state_q       <= state_d;
            scale_valid_o <= (state_q == DONE);
            if (state_q == DONE)
                scale_o <= sat_q ? '1 : quo_q;
            if (wrap && state_q != IDLE)
                overrun_o <= 1'b1;
        end
    end

    // Partial remainder holds everything above the quotient LSB window.
    assign trial    = {rem_q, low_q[SCALEBITS-1]};
    assign diff     = trial - {1'b0, sp_q};
    assign ge       = (trial >= {1'b0, sp_q});
    assign rem_next = ge ? diff[MAGBITS-1:0] : trial[MAGBITS-1:0];

    always_ff @(posedge clk_i) begin
        if (state_q == IDLE && wrap) begin
            sp_q  <= setpoint_i;
            rem_q <= mean >> HEADBITS;
            low_q <= {mean[HEADBITS-1:0], {FRACBITS{1'b0}}};
            quo_q <= '0;
            bit_q <= '0;
            sat_q <= (setpoint_i == '0) ||
                     ({{HEADBITS{1'b0}}, mean} >= {setpoint_i, {HEADBITS{1'b0}}});
        end else if (state_q == DIV) begin
            rem_q <= rem_next;
            low_q <= low_q << 1;
            quo_q <= {quo_q[SCALEBITS-2:0], ge};
            bit_q <= bit_q + BITW'(1);
        end
    end

    // Bypass is pre-shifted so both modes share the same output stage.
    assign sig_ext = PRODBITS'(signal_i);
    assign scl_ext = PRODBITS'($signed({1'b0, scale_o}));
    assign prod_d  = denorm_on ? sig_ext * scl_ext : sig_ext <<< FRACBITS;

    assign sum_d   = prod_q + RND;
    assign shifted = sum_d >>> FRACBITS;

    always_comb begin
        out_d = shifted[SIGNALBITS-1:0];
        if (shifted > SAT_HI)
            out_d = SAT_HI[SIGNALBITS-1:0];
        else if (shifted < SAT_LO)
            out_d = SAT_LO[SIGNALBITS-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prod_q   <= '0;
            signal_o <= '0;
        end else begin
            prod_q   <= prod_d;
            signal_o <= out_d;
        end
    end

endmodule

// File: tb/tb_red_pitaya_denormalizer_block.sv
// Bench for red_pitaya_denormalizer_block: window-level model plus directed literal checks.
// Build with DENORM_ROUND_EN to match a rounding DUT.
module tb_red_pitaya_denormalizer_block;

    localparam int SB = 14;
    localparam int CB = 16;
    localparam int FB = 12;
    localparam int WL = 4;

    logic                 clk = 1'b0;
    logic                 rst_i = 1'b1;
    logic                 denorm_on = 1'b1;
    logic signed [SB-1:0] signal_i = '0;
    logic signed [SB-1:0] amplitude_i = '0;
    logic        [SB-2:0] setpoint_i = '0;
    logic signed [SB-1:0] signal_o;
    logic        [CB-1:0] scale_o;
    logic                 scale_valid_o;
    logic                 overrun_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    red_pitaya_denormalizer_block #(
        .SIGNALBITS(SB),
        .SCALEBITS(CB),
        .FRACBITS(FB),
        .WINDOW_LOG2(WL)
    ) u_dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .denorm_on(denorm_on),
        .signal_i(signal_i),
        .amplitude_i(amplitude_i),
        .setpoint_i(setpoint_i),
        .signal_o(signal_o),
        .scale_o(scale_o),
        .scale_valid_o(scale_valid_o),
        .overrun_o(overrun_o)
    );

    function automatic int absf(int a);
        return (a < 0) ? -a - 1 : a;
    endfunction

    function automatic int quotf(int mean, int sp);
        if (sp == 0 || mean >= sp * (1 << (CB - FB)))
            return (1 << CB) - 1;
        return (mean * (1 << FB)) / sp;
    endfunction

    function automatic int outf(int s, bit on, int sc);
        longint p;
        if (!on)
            return s;
        p = longint'(s) * longint'(sc);
`ifdef DENORM_ROUND_EN
        p = p + (1 << (FB - 1));
`endif
        p = p >>> FB;
        if (p > (1 << (SB - 1)) - 1)
            return (1 << (SB - 1)) - 1;
        if (p < -(1 << (SB - 1)))
            return -(1 << (SB - 1));
        return int'(p);
    endfunction

    int m_t = 0;
    int m_n, m_sum, m_prev_abs, m_mean;
    int m_scale, m_q, m_done_at, m_p1, m_out;
    bit m_valid, m_ovr, m_pend, m_win, m_done_now;

    always @(posedge clk) begin
        m_t++;
        if (rst_i) begin
            m_n = 0; m_sum = 0; m_scale = 1 << FB;
            m_valid = 0; m_ovr = 0; m_pend = 0;
            m_p1 = 0; m_out = 0;
        end else begin
            m_out = m_p1;
            m_p1  = outf(int'(signal_i), denorm_on, m_scale);
            m_sum = m_sum + m_prev_abs;
            m_n++;
            m_win = 0;
            if (m_n == (1 << WL)) begin
                m_mean = m_sum >> WL;
                m_sum = 0; m_n = 0; m_win = 1;
            end
            m_done_now = m_pend && (m_t == m_done_at);
            m_valid = m_done_now;
            if (m_done_now)
                m_scale = m_q;
            if (m_win) begin
                if (m_pend) begin
                    m_ovr = 1;
                end else begin
                    m_q = quotf(m_mean, int'(setpoint_i));
                    m_pend = 1;
                    m_done_at = m_t + CB + 1;
                end
            end
            if (m_done_now)
                m_pend = 0;
        end
        m_prev_abs = absf(int'(amplitude_i));
        #1;
        checks++;
        if (int'(signal_o) != m_out || int'(scale_o) != m_scale ||
            scale_valid_o !== m_valid || overrun_o !== m_ovr) begin
            errors++;
            $display("FAIL cycle t=%0d: out/scale/valid/ovr got %0d %0d %0b %0b, required %0d %0d %0b %0b",
                     m_t, signal_o, scale_o, scale_valid_o, overrun_o,
                     m_out, m_scale, m_valid, m_ovr);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic wait_valid();
        bit found = 0;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            if (scale_valid_o) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_valid: got no pulse, required one within 80 cycles");
        end
    endtask

    task automatic apply(input int s, input string name, input int exp);
        signal_i = SB'(s);
        repeat (2) @(negedge clk);
        chk(name, int'(signal_o), exp);
    endtask

    int pulses;

    initial begin
        amplitude_i = 2000;
        setpoint_i  = 4000;
        repeat (3) @(negedge clk);
        chk("reset_signal", int'(signal_o), 0);
        chk("reset_scale", int'(scale_o), 4096);
        chk("reset_overrun", int'(overrun_o), 0);
        chk("reset_valid", int'(scale_valid_o), 0);
        rst_i = 0;
        apply(1000, "unity_after_reset", 1000);

        wait_valid();
        chk("scale_basic", int'(scale_o), 2048);
        apply(1000, "half_pos", 500);
        apply(-1000, "half_neg", -500);
        chk("overrun_set", int'(overrun_o), 1);

        amplitude_i = -2000;
        repeat (3) wait_valid();
        chk("scale_neg_amp", int'(scale_o), 2046);

        amplitude_i = 2000;
        repeat (3) wait_valid();
        chk("scale_restore", int'(scale_o), 2048);
`ifdef DENORM_ROUND_EN
        apply(3, "round_pos", 2);
        apply(-3, "round_neg", -1);
`else
        apply(3, "floor_pos", 1);
        apply(-3, "floor_neg", -2);
`endif

        setpoint_i  = 0;
        amplitude_i = 100;
        repeat (3) wait_valid();
        chk("scale_sat", int'(scale_o), 65535);
        apply(1000, "sat_hi", 8191);
        apply(-1000, "sat_lo", -8192);
        denorm_on = 0;
        apply(-1000, "bypass", -1000);
        denorm_on = 1;
        chk("overrun_sticky", int'(overrun_o), 1);

        wait_valid();
        repeat (23) @(negedge clk);
        rst_i = 1;
        @(negedge clk);
        rst_i = 0;
        pulses = 0;
        repeat (20) begin
            @(negedge clk);
            if (scale_valid_o) pulses++;
        end
        chk("abort_no_pulse", pulses, 0);
        chk("abort_scale", int'(scale_o), 4096);
        chk("abort_overrun", int'(overrun_o), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/red_pitaya_denormalizer_block.md
# red_pitaya_denormalizer_block

Restores absolute amplitude to a signal that an upstream normalizer has locked at a fixed setpoint: signal_o = signal_i · mean|amplitude_i| / setpoint_i. The amplitude reference (e.g. a DC-power monitor) is averaged over a power-of-two window. A serial restoring divider then computes an unsigned fixed-point scale once per window, and a pipelined multiplier applies the scale to the stream. It sits in the DSP chain directly after the normalizer, or on a separate output path that must track real power.

## Interface
- SIGNALBITS, 14, width of all signed data signals
- SCALEBITS, 16, width of unsigned scale factor
- FRACBITS, 12, fractional bits of scale (1.0 = 2^FRACBITS)
- WINDOW_LOG2, 10, log2 of averaging window length in cycles
- clk_i  input  1  system clock
- rst_i  input  1  synchronous, active-high reset
- denorm_on  input  1  1: scaled output; 0: bypass
- signal_i  input  SIGNALBITS signed  normalized input signal
- amplitude_i  input  SIGNALBITS signed  amplitude reference
- setpoint_i  input  SIGNALBITS-1 unsigned  normalizer setpoint (same value as upstream)
- signal_o  output  SIGNALBITS signed  denormalized signal
- scale_o  output  SCALEBITS unsigned  current scale, FRACBITS fractional
- scale_valid_o  output  1  one-cycle pulse when scale_o updates
- overrun_o  output  1  sticky: window finished while divider busy

## Operation
- Abs: amplitude_i negative → bitwise inverse (ones complement, no +1), else unchanged; result SIGNALBITS-1 bits, registered.
- Accumulator: WINDOW_LOG2+SIGNALBITS-1 bits, never overflows. Counter wraps at 2^WINDOW_LOG2-1. At wrap, mean = (acc + current sample) >> WINDOW_LOG2 and the accumulator restarts from 0.
- Mean hand-off: divider IDLE → mean and setpoint_i latched, start DIV. Divider not IDLE → mean discarded, overrun_o set (cleared only by reset).
- FSM states: IDLE, DIV, DONE.
  - IDLE→DIV on accepted mean.
  - In the DIV entry check: setpoint==0, or mean ≥ setpoint·2^(SCALEBITS-FRACBITS) → quotient forced to 2^SCALEBITS-1; DIV still lasts full length (constant latency).
  - Otherwise restoring division of mean·2^FRACBITS by setpoint, one quotient bit per cycle, MSB first, SCALEBITS cycles; quotient truncated.
  - DIV→DONE after SCALEBITS cycles. DONE: scale_o ← quotient, scale_valid_o=1, →IDLE.
- Output path:
  - Stage 1: product = signal_i × {0,scale_o}, SIGNALBITS+SCALEBITS+1 bits signed.
  - Stage 2: shift right FRACBITS, saturate to [-2^(SIGNALBITS-1), 2^(SIGNALBITS-1)-1], register.
  - denorm_on=0 → signal_i delayed through the same 2 registers (equal latency).
- Setpoint changes mid-division are ignored until the next window.

## Timing
- Reset values:
  - signal_o=0, scale_o=2^FRACBITS (1.0), scale_valid_o=0, overrun_o=0.
  - FSM IDLE, counter 0, accumulator 0.
- Reset mid-DIV aborts the division: no scale_valid_o pulse; scale returns to 1.0.
- signal_i→signal_o latency: 2 cycles, both modes.
- Window end (cycle w, counter at max) → DIV entry w+1 → DONE w+1+SCALEBITS → scale_o valid w+2+SCALEBITS → first scaled signal_o 2 cycles later.
- Window closing in the same cycle as DONE: counts as busy → overrun.
- No overrun possible when 2^WINDOW_LOG2 ≥ SCALEBITS+2.

## Configuration
- DENORM_ROUND_EN defined: stage 2 adds 2^(FRACBITS-1) before shifting (round half up), then saturates.
- DENORM_ROUND_EN undefined: plain arithmetic shift (floor).

## Test plan
- Reset check: assert rst_i for 3 cycles → signal_o=0, scale_o=4096, overrun_o=0; release, signal_i=1000 → signal_o=1000 two cycles later.
- Basic scaling: WINDOW_LOG2=4, amplitude_i=2000, setpoint_i=4000 → after first window scale_o=2048 with one scale_valid_o pulse; then signal_i=1000 → signal_o=500, signal_i=-1000 → -500.
- Negative amplitude: amplitude_i=-2000, setpoint_i=4000 → scale_o=2046 (mean 1999).
- Saturation, zero setpoint: setpoint_i=0, amplitude_i=100 → scale_o=65535; signal_i=1000 → signal_o=8191; signal_i=-1000 → -8192.
- Overrun and reset abort:
  - WINDOW_LOG2=2 → overrun_o rises at the second window and stays 1; scale_o still updates every accepted division.
  - rst_i pulsed mid-DIV → no valid pulse, scale_o=4096.
- Rounding: scale 2048, signal_i=3 → signal_o=2 with DENORM_ROUND_EN, 1 without; signal_i=-3 → -1 with, -2 without.
